// File: rtl/line_window_3x3_pkg.sv
// Shared constants and pixel type for the 3x3 line-buffered window generator.
package line_window_3x3_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned IMG_W_DEF = 28;
  localparam int unsigned IMG_H_DEF = 28;

  typedef logic signed [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/line_window_3x3_line_delay.sv
// Enable-gated DEPTH-entry pixel delay built on a circular buffer; output is the
// entry written DEPTH accepted pixels ago (read-before-write at the pointer).
module line_delay
  import line_window_3x3_pkg::*;
#(
  parameter int unsigned DEPTH = IMG_W_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  pixel_t din_i,
  output pixel_t dout_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pixel_t           mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  assign dout_c = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is never reset: stale entries are overwritten before a valid window uses them.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/line_window_3x3.sv
// Raster-scan 3x3 window generator: two row delays feed a shifting register
// window; completed windows are captured into output registers with valid_out.
module line_window_3x3
  import line_window_3x3_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     clear,
  output logic signed [DATA_W-1:0] data_out0,
  output logic signed [DATA_W-1:0] data_out1,
  output logic signed [DATA_W-1:0] data_out2,
  output logic signed [DATA_W-1:0] data_out3,
  output logic signed [DATA_W-1:0] data_out4,
  output logic signed [DATA_W-1:0] data_out5,
  output logic signed [DATA_W-1:0] data_out6,
  output logic signed [DATA_W-1:0] data_out7,
  output logic signed [DATA_W-1:0] data_out8,
  output logic                     valid_out,
  output logic                     frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  pixel_t           win_q [9];
  pixel_t           win_d [9];
  pixel_t           out_q [9];
  pixel_t           out_d [9];

  logic   accept_c;
  logic   col_last_c;
  logic   row_last_c;
  logic   win_ok_c;
  pixel_t line1_c;
  pixel_t line2_c;

  assign accept_c   = valid_in & ~clear;
  assign col_last_c = (col_q == COL_W'(IMG_W - 1));
  assign row_last_c = (row_q == ROW_W'(IMG_H - 1));
  assign win_ok_c   = accept_c && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  line_delay #(.DEPTH(IMG_W)) u_line1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (accept_c),
    .din_i  (data_in),
    .dout_c (line1_c)
  );

  line_delay #(.DEPTH(IMG_W)) u_line2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (accept_c),
    .din_i  (line1_c),
    .dout_c (line2_c)
  );

  // Counters, window shift and output capture; clear overrides an incoming pixel.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    win_d   = win_q;
    out_d   = out_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (valid_in) begin
      if (col_last_c) begin
        col_d = '0;
        row_d = row_last_c ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = line2_c;
      win_d[5] = line1_c;
      win_d[8] = data_in;
      valid_d  = win_ok_c;
      done_d   = col_last_c && row_last_c;
      if (win_ok_c) begin
        out_d = win_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
      out_q   <= out_d;
    end
  end

  assign data_out0  = out_q[0];
  assign data_out1  = out_q[1];
  assign data_out2  = out_q[2];
  assign data_out3  = out_q[3];
  assign data_out4  = out_q[4];
  assign data_out5  = out_q[5];
  assign data_out6  = out_q[6];
  assign data_out7  = out_q[7];
  assign data_out8  = out_q[8];
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Self-checking bench for line_window_3x3 (4x4 frames) against an image-array model.
module tb_line_window_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in;
  logic              clear;
  logic signed [7:0] data_in;
  logic signed [7:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
  logic              valid_out;
  logic              frame_done;

  always #5 clk = ~clk;

  line_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .clear      (clear),
    .data_out0  (d0),
    .data_out1  (d1),
    .data_out2  (d2),
    .data_out3  (d3),
    .data_out4  (d4),
    .data_out5  (d5),
    .data_out6  (d6),
    .data_out7  (d7),
    .data_out8  (d8),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  wire [71:0] dut_win = {d0, d1, d2, d3, d4, d5, d6, d7, d8};

  int          n_cmp = 0;
  int          n_bad = 0;
  int          img [H][W];
  int          m_row, m_col;
  logic [71:0] exp_win;
  logic        exp_valid, exp_fd;
  bit          chk_en = 1'b0;
  logic [71:0] cap_q [$];
  logic [71:0] ref_q [$];
  int          fd_cnt = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Window ending at pixel (r,c): rows r-2..r, cols c-2..c, row-major, first in top byte.
  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w = {w[63:0], 8'(img[r-2+dr][c-2+dc])};
    return w;
  endfunction

  // Window of a 4-wide image whose top-left pixel value is base and values increase by one.
  function automatic logic [71:0] mkw(input int base);
    int offs [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [71:0] w = '0;
    for (int i = 0; i < 9; i++) w = {w[63:0], 8'(base + offs[i])};
    return w;
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0; exp_win = '0; exp_valid = 1'b0; exp_fd = 1'b0;
  endtask

  task automatic step(input bit v, input logic signed [7:0] d, input bit clr);
    valid_in = v; data_in = d; clear = clr;
    @(posedge clk);
    if (clr) begin
      m_row = 0; m_col = 0; exp_valid = 1'b0; exp_fd = 1'b0;
    end else if (v) begin
      img[m_row][m_col] = int'(d);
      exp_valid = (m_row >= 2) && (m_col >= 2);
      if (exp_valid) exp_win = model_win(m_row, m_col);
      exp_fd = (m_row == H-1) && (m_col == W-1);
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end else begin
      exp_valid = 1'b0; exp_fd = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic frame(input int base);
    for (int k = 0; k < W*H; k++) step(1'b1, 8'(base + k), 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_out", 72'(valid_out), 72'(exp_valid));
      check("frame_done", 72'(frame_done), 72'(exp_fd));
      check("window", dut_win, exp_win);
      if (valid_out) cap_q.push_back(dut_win);
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; clear = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_window", dut_win, 72'h0);
    check("reset_valid", 72'(valid_out), 72'h0);
    check("reset_done", 72'(frame_done), 72'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Continuous 0..15 frame
    cap_q.delete(); fd_cnt = 0;
    frame(0);
    step(1'b0, 8'sd0, 1'b0);
    #1;
    check("f1_count", 72'(cap_q.size()), 72'd4);
    if (cap_q.size() == 4) begin
      check("f1_first", cap_q[0], mkw(0));
      check("f1_last", cap_q[3], mkw(5));
    end
    check("f1_done_cnt", 72'(fd_cnt), 72'd1);
    ref_q = cap_q;

    // Same frame with toggling valid and random gaps
    cap_q.delete();
    for (int k = 0; k < W*H; k++) begin
      if (k % 2 == 1) step(1'b0, 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 5)) step(1'b0, 8'($urandom), 1'b0);
      step(1'b1, 8'(k), 1'b0);
    end
    step(1'b0, 8'sd0, 1'b0);
    #1;
    check("gap_count", 72'(cap_q.size()), 72'(ref_q.size()));
    for (int i = 0; i < cap_q.size() && i < ref_q.size(); i++)
      check("gap_window", cap_q[i], ref_q[i]);

    // Back-to-back frames
    cap_q.delete();
    frame(0);
    frame(100);
    step(1'b0, 8'sd0, 1'b0);
    #1;
    check("b2b_count", 72'(cap_q.size()), 72'd8);
    if (cap_q.size() == 8) check("b2b_second_first", cap_q[4], mkw(100));

    // Reset mid-frame
    for (int k = 0; k < 8; k++) step(1'b1, 8'(k), 1'b0);
    valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_window", dut_win, 72'h0);
    check("midrst_valid", 72'(valid_out), 72'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cap_q.delete(); fd_cnt = 0;
    frame(0);
    step(1'b0, 8'sd0, 1'b0);
    #1;
    check("post_rst_count", 72'(cap_q.size()), 72'd4);
    if (cap_q.size() == 4) check("post_rst_first", cap_q[0], mkw(0));
    check("post_rst_done", 72'(fd_cnt), 72'd1);

    // Clear coincident with the last pixel
    fd_cnt = 0;
    for (int k = 0; k < W*H-1; k++) step(1'b1, 8'(k), 1'b0);
    step(1'b1, 8'sd15, 1'b1);
    step(1'b0, 8'sd0, 1'b0);
    #1;
    check("clear_no_done", 72'(fd_cnt), 72'd0);
    cap_q.delete();
    frame(0);
    step(1'b0, 8'sd0, 1'b0);
    #1;
    if (cap_q.size() > 0) check("clear_restart", cap_q[0], mkw(0));
    else check("clear_restart_count", 72'(cap_q.size()), 72'd4);
    check("clear_next_done", 72'(fd_cnt), 72'd1);

    // Signed extremes in the first window
    cap_q.delete();
    for (int k = 0; k < W*H; k++) begin
      logic signed [7:0] v;
      v = 8'(k);
      if (k == 8)  v = 8'sd127;
      if (k == 9)  v = -8'sd1;
      if (k == 10) v = -8'sd128;
      step(1'b1, v, 1'b0);
    end
    step(1'b0, 8'sd0, 1'b0);
    #1;
    if (cap_q.size() > 0) check("signed_window", cap_q[0], 72'h000102_040506_7fff80);
    else check("signed_count", 72'(cap_q.size()), 72'd4);

    // Randomized traffic with occasional clears
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 63) == 0);
    step(1'b0, 8'sd0, 1'b0);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
